// File: rtl/mc_defs.sv
// Shared control definitions for the multicycle CPU: opcodes, state encodings,
// datapath select codes and the packed control word driven onto the datapath.
package mc_defs;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;

  // ADDI encodings exist in every build but are only reachable with ADDI enabled.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC      = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational state -> control-word decode for the multicycle control FSM.
// ADDI states decode only when MC_ADDI_EN is defined; otherwise they fall to all-zero.
module mc_ctrl_decode
  import mc_defs::*;
(
  input  state_t     i_state,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        // The top qualifies these two with mem_ready.
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_ADDI_EN
      ST_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU main control FSM: state register, next-state logic and output gating.
// Optional ADDI support is enabled by defining MC_ADDI_EN.
module mc_control_fsm
  import mc_defs::*;
#(
  parameter int OPW = OPCODE_W,
  parameter int STW = STATE_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic [STW-1:0] state_o
);

  // Handshake: memory asserts mem_ready in the cycle an access completes; the
  // request (mem_read/mem_write) is held and the FSM stays put until then.
  state_t     r_state;
  state_t     w_next;
  ctrl_word_t w_ctrl;
  logic       w_illegal;
  logic       w_fetch_gate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = ST_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      ST_FETCH:     w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (is_mem_op(opcode)) begin
          w_next = ST_MEM_ADDR;
        end else begin
          case (opcode)
            OP_RTYPE: w_next = ST_EXEC;
            OP_BEQ:   w_next = ST_BRANCH;
            OP_J:     w_next = ST_JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:  w_next = ST_ADDI_EXEC;
`endif
            default: begin
              w_next    = ST_FETCH;
              w_illegal = 1'b1;
            end
          endcase
        end
      end
      // Opcode is re-sampled here; anything other than LW/SW abandons the access.
      ST_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next = ST_MEM_READ;
        else if (opcode == OP_SW) w_next = ST_MEM_WRITE;
        else                      w_next = ST_FETCH;
      end
      ST_MEM_READ:  w_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    w_next = ST_FETCH;
      ST_MEM_WRITE: w_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXEC:      w_next = ST_R_WB;
      ST_R_WB:      w_next = ST_FETCH;
      ST_BRANCH:    w_next = ST_FETCH;
      ST_JUMP:      w_next = ST_FETCH;
`ifdef MC_ADDI_EN
      ST_ADDI_EXEC: w_next = ST_ADDI_WB;
      ST_ADDI_WB:   w_next = ST_FETCH;
`endif
      default:      w_next = ST_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // FETCH commits PC/IR only on the cycle memory delivers the instruction.
  assign w_fetch_gate = (r_state != ST_FETCH) || mem_ready;

  // rst_n gates every output so nothing is asserted while reset is held.
  assign pc_write      = rst_n & w_ctrl.pc_write & w_fetch_gate;
  assign ir_write      = rst_n & w_ctrl.ir_write & w_fetch_gate;
  assign pc_write_cond = rst_n & w_ctrl.pc_write_cond;
  assign iord          = rst_n & w_ctrl.iord;
  assign mem_read      = rst_n & w_ctrl.mem_read;
  assign mem_write     = rst_n & w_ctrl.mem_write;
  assign mem_to_reg    = rst_n & w_ctrl.mem_to_reg;
  assign reg_dst       = rst_n & w_ctrl.reg_dst;
  assign reg_write     = rst_n & w_ctrl.reg_write;
  assign alu_src_a     = rst_n & w_ctrl.alu_src_a;
  assign alu_src_b     = {2{rst_n}} & w_ctrl.alu_src_b;
  assign alu_op        = {2{rst_n}} & w_ctrl.alu_op;
  assign pc_source     = {2{rst_n}} & w_ctrl.pc_source;
  assign illegal_op    = rst_n & w_illegal;
  assign state_o       = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, reset-abort sequence and a
// randomized instruction stream checked against a per-instruction step-list model.
module tb_mc_control_fsm;
  import mc_defs::*;

  typedef enum {
    S_FETCH, S_DECODE, S_DECODE_ILL, S_MADDR, S_MREAD, S_MWB, S_MWRITE,
    S_EXEC, S_RWB, S_BR, S_JMP, S_AEXEC, S_AWB
  } step_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    step_e      step;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
  logic [20:0] act;

  int n_vec = 0;
  int n_err = 0;
  logic [20:0] exp_q[$];
  step_e       step_q[$];
  vec_t        tbl[$];
  logic [5:0]  cur_op;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_o(state_o)
  );

  assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op, state_o};

  // clock / reset
  always #5 clk = ~clk;

  function automatic ctrl_t ctrl_of(input step_e s, input logic rdy);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:      begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = rdy; c.ir_write = rdy; end
      S_DECODE:     c.alu_src_b = 2'b11;
      S_DECODE_ILL: begin c.alu_src_b = 2'b11; c.illegal_op = 1; end
      S_MADDR:      begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_MREAD:      begin c.mem_read = 1; c.iord = 1; end
      S_MWB:        begin c.reg_write = 1; c.mem_to_reg = 1; end
      S_MWRITE:     begin c.mem_write = 1; c.iord = 1; end
      S_EXEC:       begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      S_RWB:        begin c.reg_dst = 1; c.reg_write = 1; end
      S_BR:         begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      S_JMP:        begin c.pc_write = 1; c.pc_source = 2'b10; end
      S_AEXEC:      begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b00; end
      S_AWB:        c.reg_write = 1;
      default:      c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] state_of(input step_e s);
    case (s)
      S_FETCH:                 return ST_FETCH;
      S_DECODE, S_DECODE_ILL:  return ST_DECODE;
      S_MADDR:                 return ST_MEM_ADDR;
      S_MREAD:                 return ST_MEM_READ;
      S_MWB:                   return ST_MEM_WB;
      S_MWRITE:                return ST_MEM_WRITE;
      S_EXEC:                  return ST_EXEC;
      S_RWB:                   return ST_R_WB;
      S_BR:                    return ST_BRANCH;
      S_JMP:                   return ST_JUMP;
      S_AEXEC:                 return ST_ADDI_EXEC;
      default:                 return ST_ADDI_WB;
    endcase
  endfunction

  function automatic logic [20:0] exp_word(input step_e s, input logic rdy);
    return {ctrl_of(s, rdy), state_of(s)};
  endfunction

  function automatic logic waits_mem(input step_e s);
    return (s == S_FETCH) || (s == S_MREAD) || (s == S_MWRITE);
  endfunction

  // Reference: the sequence of steps one instruction walks through.
  task automatic build_steps(input logic [5:0] op);
    step_q.push_back(S_FETCH);
    case (op)
      6'h00: begin step_q.push_back(S_DECODE); step_q.push_back(S_EXEC);  step_q.push_back(S_RWB); end
      6'h23: begin step_q.push_back(S_DECODE); step_q.push_back(S_MADDR); step_q.push_back(S_MREAD); step_q.push_back(S_MWB); end
      6'h2B: begin step_q.push_back(S_DECODE); step_q.push_back(S_MADDR); step_q.push_back(S_MWRITE); end
      6'h04: begin step_q.push_back(S_DECODE); step_q.push_back(S_BR); end
      6'h02: begin step_q.push_back(S_DECODE); step_q.push_back(S_JMP); end
`ifdef MC_ADDI_EN
      6'h08: begin step_q.push_back(S_DECODE); step_q.push_back(S_AEXEC); step_q.push_back(S_AWB); end
`endif
      default: step_q.push_back(S_DECODE_ILL);
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 5)];
    return 6'($urandom);
  endfunction

  // scoreboard
  task automatic check(input string name);
    logic [20:0] e;
    e = exp_q.pop_front();
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  // driver: inputs just after posedge, compare at negedge
  task automatic apply(input vec_t v, input string name);
    opcode    = v.op;
    mem_ready = v.rdy;
    exp_q.push_back(exp_word(v.step, v.rdy));
    @(negedge clk);
    check(name);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input step_e s);
    vec_t v;
    v.op = op; v.rdy = rdy; v.step = s;
    tbl.push_back(v);
  endtask

  initial begin
    // Fetch stall, then R-type with distractor opcodes outside DECODE
    add(6'h2B, 0, S_FETCH); add(6'h00, 0, S_FETCH); add(6'h00, 1, S_FETCH);
    add(6'h00, 0, S_DECODE); add(6'h2B, 1, S_EXEC); add(6'h04, 1, S_RWB);
    // LW with three memory stalls
    add(6'h23, 1, S_FETCH); add(6'h23, 1, S_DECODE); add(6'h23, 0, S_MADDR);
    add(6'h2B, 0, S_MREAD); add(6'h00, 0, S_MREAD); add(6'h02, 0, S_MREAD);
    add(6'h3F, 1, S_MREAD); add(6'h2B, 0, S_MWB);
    // SW, BEQ, J
    add(6'h00, 1, S_FETCH); add(6'h2B, 1, S_DECODE); add(6'h2B, 1, S_MADDR); add(6'h23, 1, S_MWRITE);
    add(6'h00, 1, S_FETCH); add(6'h04, 1, S_DECODE); add(6'h23, 1, S_BR);
    add(6'h00, 1, S_FETCH); add(6'h02, 1, S_DECODE); add(6'h00, 1, S_JMP);
    // ADDI opcode and a plainly illegal opcode
    add(6'h00, 1, S_FETCH);
`ifdef MC_ADDI_EN
    add(6'h08, 1, S_DECODE); add(6'h23, 1, S_AEXEC); add(6'h2B, 1, S_AWB);
`else
    add(6'h08, 1, S_DECODE_ILL);
`endif
    add(6'h00, 1, S_FETCH); add(6'h3F, 1, S_DECODE_ILL);
    add(6'h00, 0, S_FETCH);

    // Reset state: all outputs low even with mem_ready high
    mem_ready = 1'b1;
    exp_q.push_back({17'h0, ST_FETCH});
    @(negedge clk);
    check("reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("table_%0d", i));

    // Reset in the middle of a stalled SW
    add(6'h00, 1, S_FETCH); add(6'h2B, 1, S_DECODE); add(6'h2B, 1, S_MADDR);
    for (int i = tbl.size() - 3; i < tbl.size(); i++) apply(tbl[i], $sformatf("sw_pre_%0d", i));
    opcode = 6'h2B; mem_ready = 1'b0;
    exp_q.push_back(exp_word(S_MWRITE, 1'b0));
    @(negedge clk);
    check("sw_stall");
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back({17'h0, ST_FETCH});
    check("reset_abort");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b0;
    exp_q.push_back(exp_word(S_FETCH, 1'b0));
    @(negedge clk);
    check("after_release");
    @(posedge clk);
    #1;

    // Randomized instruction stream against the step-list model
    step_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step_e s;
      if (step_q.size() == 0) begin
        cur_op = pick_op();
        build_steps(cur_op);
      end
      s = step_q[0];
      opcode = (s == S_DECODE || s == S_DECODE_ILL || s == S_MADDR) ? cur_op : 6'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      exp_q.push_back(exp_word(s, mem_ready));
      @(negedge clk);
      check($sformatf("rand_%0d_op%h", cyc, cur_op));
      if (!waits_mem(s) || mem_ready) void'(step_q.pop_front());
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
